// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode enum, width-generic compute function and the
// payload struct macro used by every pipeline slot.
`ifndef ALU_PKG_SV
`define ALU_PKG_SV

// Payload widths come from the instantiating module's parameters, so the struct is a macro.
`define ALU_PAYLOAD_T(W, TW) struct packed { logic [(W)-1:0] result; logic [(TW)-1:0] tag; logic zero; logic ovf; logic illegal; }

package alu_pkg;

    localparam int ALU_MAX_W = 64;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SLL  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_SLTU = 4'b1000,
        OP_NOR  = 4'b1100,
        OP_SRA  = 4'b1101
    } alu_op_t;

    typedef struct packed {
        logic [ALU_MAX_W-1:0] result;
        logic                 ovf;
        logic                 illegal;
    } alu_calc_t;

    // Operands arrive zero-extended to ALU_MAX_W; w is the live width (power of 2,
    // 8..ALU_MAX_W). Bits above w in the returned result are always zero.
    function automatic alu_calc_t alu_compute(input logic [ALU_MAX_W-1:0] a,
                                              input logic [ALU_MAX_W-1:0] b,
                                              input alu_op_t              op,
                                              input int unsigned          w);
        alu_calc_t            c;
        logic [ALU_MAX_W-1:0] mask;
        logic [ALU_MAX_W-1:0] sign_bit;
        logic [ALU_MAX_W-1:0] a_m;
        logic [ALU_MAX_W-1:0] b_m;
        logic [ALU_MAX_W-1:0] b_neg;
        logic [ALU_MAX_W-1:0] a_sx;
        logic [ALU_MAX_W-1:0] b_sx;
        logic [ALU_MAX_W-1:0] shamt;
        logic                 sa;
        logic                 sb;
        logic                 sbn;
        logic                 sr;

        c        = '0;
        mask     = {ALU_MAX_W{1'b1}} >> (ALU_MAX_W - w);
        sign_bit = {{(ALU_MAX_W-1){1'b0}}, 1'b1} << (w - 1);
        a_m      = a & mask;
        b_m      = b & mask;
        b_neg    = (~b_m + 1'b1) & mask;
        sa       = |(a_m & sign_bit);
        sb       = |(b_m & sign_bit);
        sbn      = |(b_neg & sign_bit);
        a_sx     = sa ? (a_m | ~mask) : a_m;
        b_sx     = sb ? (b_m | ~mask) : b_m;
        shamt    = b_m & ALU_MAX_W'(w - 1);

        case (op)
            OP_AND:  c.result = a_m & b_m;
            OP_OR:   c.result = a_m | b_m;
            OP_XOR:  c.result = a_m ^ b_m;
            OP_NOR:  c.result = ~(a_m | b_m) & mask;
            OP_ADD: begin
                c.result = (a_m + b_m) & mask;
                sr       = |(c.result & sign_bit);
                c.ovf    = (sa == sb) && (sr != sa);
            end
            OP_SUB: begin
                c.result = (a_m - b_m) & mask;
                sr       = |(c.result & sign_bit);
                c.ovf    = (sa == sbn) && (sr != sa);
            end
            OP_SLT:  c.result[0] = ($signed(a_sx) < $signed(b_sx));
            OP_SLTU: c.result[0] = (a_m < b_m);
            OP_SLL:  c.result = (a_m << shamt) & mask;
            OP_SRL:  c.result = a_m >> shamt;
            OP_SRA:  c.result = ALU_MAX_W'($signed(a_sx) >>> shamt) & mask;
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

`endif

// File: rtl/alu_pipe_if.sv
// Request/response bundle between the issue side and the pipelined ALU.
interface alu_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [3:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;
    logic             out_ovf;
    logic             out_illegal;
    logic [CNT_W-1:0] op_count;

    modport master (
        output in_valid, in_a, in_b, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_zero, out_ovf, out_illegal, op_count
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_zero, out_ovf, out_illegal, op_count
    );
endinterface

// File: rtl/alu_pipe_stage.sv
// One elastic valid/ready register slot; the ready chain is resolved by the parent,
// so this slot simply loads whenever it is empty or its content is being taken.
module alu_pipe_stage #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  T     in_data,
    input  logic out_ready,
    output logic out_valid,
    output T     out_data
);
    logic valid_q;
    logic valid_d;
    T     data_q;
    T     data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (!valid_q || out_ready) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU: combinational compute into a chain of STAGES elastic slots,
// with result flags and a saturating count of delivered results.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_pipe_if.slave    bus
);
    typedef `ALU_PAYLOAD_T(WIDTH, TAG_W) payload_t;

    // Index 0 is the input port, index STAGES is the output port.
    logic     stage_valid [STAGES+1];
    logic     stage_ready [STAGES+1];
    payload_t stage_data  [STAGES+1];

    alu_calc_t calc;
    payload_t  in_payload;

    always_comb begin
        calc               = alu_compute(ALU_MAX_W'(bus.in_a), ALU_MAX_W'(bus.in_b),
                                         alu_op_t'(bus.in_op), WIDTH);
        in_payload         = '0;
        in_payload.result  = calc.result[WIDTH-1:0];
        in_payload.tag     = bus.in_tag;
        in_payload.zero    = (calc.result == '0);
        in_payload.ovf     = calc.ovf;
        in_payload.illegal = calc.illegal;
    end

    assign stage_valid[0] = bus.in_valid;
    assign stage_data[0]  = in_payload;

    // Ready walks back from the consumer through every slot in one block, so a full
    // pipe can hand off and accept on the same edge without an inter-instance loop.
    always_comb begin
        logic rdy;
        rdy                 = bus.out_ready;
        stage_ready[STAGES] = bus.out_ready;
        for (int i = STAGES; i >= 1; i--) begin
            rdy              = !stage_valid[i] || rdy;
            stage_ready[i-1] = rdy;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            alu_pipe_stage #(
                .T (payload_t)
            ) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (stage_valid[gi]),
                .in_data   (stage_data[gi]),
                .out_ready (stage_ready[gi+1]),
                .out_valid (stage_valid[gi+1]),
                .out_data  (stage_data[gi+1])
            );
        end
    endgenerate

    assign bus.in_ready    = stage_ready[0];
    assign bus.out_valid   = stage_valid[STAGES];
    assign bus.out_result  = stage_data[STAGES].result;
    assign bus.out_tag     = stage_data[STAGES].tag;
    assign bus.out_zero    = stage_data[STAGES].zero;
    assign bus.out_ovf     = stage_data[STAGES].ovf;
    assign bus.out_illegal = stage_data[STAGES].illegal;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (stage_valid[STAGES] && bus.out_ready && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.op_count = cnt_q;
endmodule
